// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } seq_state_t;

  localparam int CNT_W_DEF = 16;

  // Number of complete KxK windows in a WxH frame at stride S.
  function automatic int n_windows(input int w, input int h, input int k, input int s);
    return ((w - k) / s + 1) * ((h - k) / s + 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that returns to zero after reaching a runtime maximum.
module wrap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_r;

  assign cnt  = cnt_r;
  assign wrap = (cnt_r == max);

  // Counter state; clr wins over en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= wrap ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Tags a raster pixel stream with row/column and flags completed KxK windows
// on the stride grid, with one-entry output buffering and frame sequencing.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_col,
  output logic [CNT_W-1:0]  out_row,
  output logic              out_win,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic [CNT_W-1:0]  win_count
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] PH_MAX  = CNT_W'(STRIDE - 1);
  localparam logic [CNT_W-1:0] K_M1    = CNT_W'(K - 1);

  seq_state_t        state_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CNT_W-1:0]  out_col_r;
  logic [CNT_W-1:0]  out_row_r;
  logic              out_win_r;
  logic              out_eol_r;
  logic              out_eof_r;
  logic              frame_done_r;
  logic [CNT_W-1:0]  win_count_r;

  logic             acc_s;
  logic             hs_s;
  logic [CNT_W-1:0] col_s;
  logic [CNT_W-1:0] row_s;
  logic [CNT_W-1:0] col_ph_s;
  logic [CNT_W-1:0] row_ph_s;
  logic             col_wrap_s;
  logic             row_wrap_s;
  logic             col_ph_wrap_s;
  logic             row_ph_wrap_s;
  logic             col_in_s;
  logic             row_in_s;
  logic             win_s;
  logic             eof_s;
  logic             unused_s;

  assign in_ready = (state_r != DRAIN) && (!out_valid_r || out_ready);
  assign acc_s    = in_valid && in_ready && !clr;
  assign hs_s     = out_valid_r && out_ready && !clr;

  // Written as >/== so that K=1 does not collapse into an always-true compare.
  assign col_in_s = (col_s > K_M1) || (col_s == K_M1);
  assign row_in_s = (row_s > K_M1) || (row_s == K_M1);
  assign win_s    = col_in_s && row_in_s &&
                    (col_ph_s == {CNT_W{1'b0}}) && (row_ph_s == {CNT_W{1'b0}});
  assign eof_s    = col_wrap_s && row_wrap_s;
  assign unused_s = ^{col_ph_wrap_s, row_ph_wrap_s};

  wrap_counter #(.CNT_W(CNT_W)) u_col (
    .clk(clk), .rst_n(rst_n), .en(acc_s), .clr(clr), .max(COL_MAX),
    .cnt(col_s), .wrap(col_wrap_s)
  );

  wrap_counter #(.CNT_W(CNT_W)) u_row (
    .clk(clk), .rst_n(rst_n), .en(acc_s && col_wrap_s), .clr(clr), .max(ROW_MAX),
    .cnt(row_s), .wrap(row_wrap_s)
  );

  // Phases restart at every row / frame boundary so the grid is anchored at K-1.
  wrap_counter #(.CNT_W(CNT_W)) u_col_ph (
    .clk(clk), .rst_n(rst_n), .en(acc_s && col_in_s),
    .clr(clr || (acc_s && col_wrap_s)), .max(PH_MAX),
    .cnt(col_ph_s), .wrap(col_ph_wrap_s)
  );

  wrap_counter #(.CNT_W(CNT_W)) u_row_ph (
    .clk(clk), .rst_n(rst_n), .en(acc_s && col_wrap_s && row_in_s),
    .clr(clr || (acc_s && eof_s)), .max(PH_MAX),
    .cnt(row_ph_s), .wrap(row_ph_wrap_s)
  );

  // Frame FSM, output register and window accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      out_data_r   <= {DATA_W{1'b0}};
      out_col_r    <= {CNT_W{1'b0}};
      out_row_r    <= {CNT_W{1'b0}};
      out_win_r    <= 1'b0;
      out_eol_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      frame_done_r <= 1'b0;
      win_count_r  <= {CNT_W{1'b0}};
    end else if (clr) begin
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (acc_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data;
        out_col_r   <= col_s;
        out_row_r   <= row_s;
        out_win_r   <= win_s;
        out_eol_r   <= col_wrap_s;
        out_eof_r   <= eof_s;
      end else if (hs_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      case (state_r)
        IDLE: begin
          if (acc_s) begin
            state_r <= eof_s ? DRAIN : ACTIVE;
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (acc_s && eof_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= ACTIVE;
          end
        end
        DRAIN: begin
          if (hs_s && out_eof_r) begin
            state_r      <= IDLE;
            frame_done_r <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if ((state_r == IDLE) && acc_s) begin
        win_count_r <= {CNT_W{1'b0}};
      end else if (hs_s && out_win_r) begin
        win_count_r <= win_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        win_count_r <= win_count_r;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_col    = out_col_r;
  assign out_row    = out_row_r;
  assign out_win    = out_win_r;
  assign out_eol    = out_eol_r;
  assign out_eof    = out_eof_r;
  assign frame_done = frame_done_r;
  assign win_count  = win_count_r;

endmodule
